ql_bus_master: RTL

- Synthesizable QL expansion-bus (68008-style, asynchronous) cycle initiator: the requesting side of the bus that the QeControl slave answers.
- Converts a single-beat request into a full asl/dsl/rdwl cycle, waits for dtackl, captures read data, and reports completion or timeout.
- Used as the bench-side and FPGA-side driver for exercising W5300 register accesses through QeControl.

---
 rtl/ql_bus_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ql_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ql_bus_master : 68008-style QL expansion-bus cycle initiator (single beat)
// Revision 1.0
// ----------------------------------------------------------------------------
module ql_bus_master #(
    parameter int ADDR_W      = 20,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 1,
    parameter int TIMEOUT_CYC = 64,
    parameter int RECOVER_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic              resp_timeout,
    output logic [ADDR_W-1:0] address,
    output logic [7:0]        data_out,
    output logic              data_oe,
    input  logic [7:0]        data_in,
    output logic              asl,
    output logic              dsl,
    output logic              rdwl,
    input  logic              dtackl
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CD  = (TIMEOUT_CYC > RECOVER_CYC) ? TIMEOUT_CYC : RECOVER_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int REC_EFF = (RECOVER_CYC > 0) ? RECOVER_CYC : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(REC_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ASTRB   = 3'd2,
        S_WAIT    = 3'd3,
        S_LATCH   = 3'd4,
        S_ABORT   = 3'd5,
        S_RECOVER = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dtack_meta;
    logic             dtack_s;

    // dtackl is asynchronous to clk; flops hold the inverted (active-high) level
    always_ff @(posedge clk) begin
        if (rst) begin
            dtack_meta <= 1'b0;
            dtack_s    <= 1'b0;
        end else begin
            dtack_meta <= ~dtackl;
            dtack_s    <= dtack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            resp_rdata   <= 8'h00;
            address      <= '0;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            asl          <= 1'b1;
            dsl          <= 1'b1;
            rdwl         <= 1'b1;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        address   <= req_addr;
                        rdwl      <= ~req_write;
                        data_out  <= req_wdata;
                        data_oe   <= req_write;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        asl   <= 1'b0;
                        cnt   <= '0;
                        state <= S_ASTRB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ASTRB: begin
                    if (cnt == STROBE_LAST) begin
                        dsl   <= 1'b0;
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // acknowledge takes priority over a simultaneous timeout
                    if (dtack_s) begin
                        if (rdwl) begin
                            resp_rdata <= data_in;
                        end
                        asl          <= 1'b1;
                        dsl          <= 1'b1;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b0;
                        state        <= S_LATCH;
                    end else if (cnt == TIMEOUT_LAST) begin
                        asl          <= 1'b1;
                        dsl          <= 1'b1;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b1;
                        state        <= S_ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LATCH, S_ABORT: begin
                    data_oe <= 1'b0;
                    rdwl    <= 1'b1;
                    cnt     <= '0;
                    state   <= S_RECOVER;
                end
                S_RECOVER: begin
                    // counter saturates; a held dtackl keeps us here
                    if (cnt == RECOVER_LAST) begin
                        if (!dtack_s) begin
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    asl       <= 1'b1;
                    dsl       <= 1'b1;
                    rdwl      <= 1'b1;
                    data_oe   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
